// File: rtl/alu_ctl.sv
// alu_ctl: sequencer for an external registered 8-bit ALU.
// It holds a 4 x 8-bit register file and reads two operands for each accepted
// instruction. It waits one cycle while the ALU registers its result, then
// writes that result back and updates the {N,Z,C,V} flags.
//
// Handshake: an instruction is accepted on a rising edge where both
// instr_valid and instr_ready are high. instr_ready is high only in IDLE and
// never while rst_n is low. instr_valid is ignored when instr_ready is low.
// The instruction word is fully captured on the accept edge, so the source
// may change instr right after that edge.
module alu_ctl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        rf_we,
  input  logic [1:0]  rf_waddr,
  input  logic [7:0]  rf_wdata,
  input  logic [1:0]  rf_raddr,
  output logic [7:0]  rf_rdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_shamt,
  input  logic [7:0]  alu_out,
  output logic [3:0]  flags,
  output logic        done,
  output logic [1:0]  dbg_state_o
);

  // ALU op codes; the controller passes them through to alu_op unchanged
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NEG = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_ORR = 3'd4;
  localparam logic [2:0] OP_EOR = 3'd5;
  localparam logic [2:0] OP_LSL = 3'd6;
  localparam logic [2:0] OP_LSR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        done_q;
  logic [1:0]  rd_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic [2:0]  sh_q;
  logic [3:0]  flags_q;
  logic [3:0]  flags_d;
  logic [7:0]  rf_q [4];

  // Instruction fields
  logic [2:0]  instr_op;
  logic [2:0]  instr_sh;
  logic [1:0]  instr_rd;
  logic [1:0]  instr_ra;
  logic [1:0]  instr_rb;
  logic        instr_rsvd_unused;
  logic        accept;

  assign instr_op          = instr[15:13];
  assign instr_sh          = instr[12:10];
  assign instr_rd          = instr[9:8];
  assign instr_ra          = instr[7:6];
  assign instr_rb          = instr[5:4];
  assign instr_rsvd_unused = ^instr[3:0];

  // ready_q resets to 1, but the output must still read 0 while reset is held
  assign instr_ready = ready_q & rst_n;
  assign accept      = instr_valid & instr_ready;

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_shamt   = sh_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Combinational read port: shows the stored value, so a write in the same
  // cycle becomes visible only after the edge
  assign rf_rdata = rf_q[rf_raddr];

  // Flag evaluation from the latched operands and the ALU result
  logic [8:0]        add_u;
  logic signed [8:0] add_s;
  logic signed [8:0] sub_s;
  logic [15:0]       lsl_w;
  logic [15:0]       lsr_w;
  logic              c_d;
  logic              v_d;

  // Next flags; C and V keep their old value unless the op defines them
  always_comb begin
    add_u = {1'b0, a_q} + {1'b0, b_q};
    add_s = $signed({a_q[7], a_q}) + $signed({b_q[7], b_q});
    sub_s = $signed({a_q[7], a_q}) - $signed({b_q[7], b_q});
    // The bit that leaves a[7] lands on bit 8 of the widened left shift.
    // The bit that leaves a[0] lands on bit 7 of the widened right shift.
    lsl_w = {8'h00, a_q} << sh_q;
    lsr_w = {a_q, 8'h00} >> sh_q;
    c_d   = flags_q[1];
    v_d   = flags_q[0];
    case (op_q)
      OP_ADD: begin
        c_d = (add_u > 9'd255);
        v_d = (add_s > 9'sd127) || (add_s < -9'sd128);
      end
      OP_SUB: begin
        c_d = (a_q >= b_q);
        v_d = (sub_s > 9'sd127) || (sub_s < -9'sd128);
      end
      OP_LSL: begin
        if (sh_q != 3'd0) c_d = ((lsl_w & 16'h0100) != 16'h0000);
      end
      OP_LSR: begin
        if (sh_q != 3'd0) c_d = ((lsr_w & 16'h0080) != 16'h0000);
      end
      OP_NEG, OP_AND, OP_ORR, OP_EOR: begin
        c_d = flags_q[1];
        v_d = flags_q[0];
      end
      default: begin
        c_d = flags_q[1];
        v_d = flags_q[0];
      end
    endcase
    flags_d = {alu_out[7], (alu_out == 8'h00), c_d, v_d};
  end

  // Control FSM: latch on accept, wait for the ALU, pulse done while capturing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rd_q    <= 2'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'd0;
      sh_q    <= 3'd0;
      flags_q <= RESET_FLAGS;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rd_q    <= instr_rd;
            a_q     <= rf_q[instr_ra];
            b_q     <= rf_q[instr_rb];
            op_q    <= instr_op;
            sh_q    <= instr_sh;
            ready_q <= 1'b0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          done_q  <= 1'b1;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          flags_q <= flags_d;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: the external write is issued first so the writeback to rd wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
    end else begin
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
      if (state_q == S_CAPTURE) rf_q[rd_q] <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_ctl.sv
// Testbench for alu_ctl: hand-derived vector table, back-to-back, write
// collision, accept-edge write, reset abort, and randomized instructions
// against a reference model.
module tb_alu_ctl;

  localparam logic [3:0] RF = 4'b0101;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, NEG = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] ORR = 3'd4, EOR = 3'd5, LSL = 3'd6, LSR = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic        rf_we = 1'b0;
  logic [1:0]  rf_waddr = 2'd0;
  logic [7:0]  rf_wdata = 8'h00;
  logic [1:0]  rf_raddr = 2'd0;
  logic [7:0]  rf_rdata;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op, alu_shamt;
  logic [7:0]  alu_out = 8'h00;
  logic [3:0]  flags;
  logic        done;
  logic [1:0]  dbg_state;

  alu_ctl #(.RESET_FLAGS(RF)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .flags(flags), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU / reference model ----------------
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic [2:0] sh);
    int ua, ub, r;
    ua = int'(a);
    ub = int'(b);
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua - ub;
      3'd2: r = 0 - ua;
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: r = ua << sh;
      default: r = ua >> sh;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [3:0] ref_flags(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] res, input logic [2:0] op,
                                           input logic [2:0] sh, input logic [3:0] old);
    int ua, ub, sa, sb, t;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = old[1];
    v = old[0];
    case (op)
      3'd0: begin c = (ua + ub) > 255; t = sa + sb; v = (t > 127) || (t < -128); end
      3'd1: begin c = ua >= ub;        t = sa - sb; v = (t > 127) || (t < -128); end
      3'd6: if (sh != 3'd0) c = (((ua << sh) >> 8) % 2) == 1;
      3'd7: if (sh != 3'd0) c = ((((ua << 8) >> sh) >> 7) % 2) == 1;
      default: ;
    endcase
    return {res[7], res == 8'h00, c, v};
  endfunction

  // Registered ALU environment: samples operands each edge
  always @(posedge clk) alu_out <= alu_fn(alu_a, alu_b, alu_op, alu_shamt);

  logic [7:0] m_r [4];
  logic [3:0] m_f;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sb_front;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every done pulse must match one queued writeback value
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) check("done_spurious", {7'b0, done}, 8'h00);
      else begin
        sb_front = exp_q.pop_front();
        check("wb_value", alu_out, sb_front);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_f = RF;
    exp_q.delete();
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      rf_raddr = 2'(i);
      #1;
      check(name, rf_rdata, m_r[i]);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    rf_raddr = addr;
    rf_we = 1'b1; rf_waddr = addr; rf_wdata = data;
    #1;
    check("rd_old_during_write", rf_rdata, m_r[addr]);
    @(posedge clk);
    #1;
    rf_we = 1'b0;
    m_r[addr] = data;
    check("rd_after_write", rf_rdata, data);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [2:0] sh, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb,
                           input logic acc_we, input logic [1:0] acc_addr, input logic [7:0] acc_data,
                           input logic cap_we, input logic [1:0] cap_addr, input logic [7:0] cap_data);
    logic [7:0] oa, ob, res;
    logic [3:0] junk;
    @(negedge clk);
    check("ready_idle", {7'b0, instr_ready}, 8'h01);
    check("done_idle", {7'b0, done}, 8'h00);
    junk = 4'($urandom);
    instr_valid = 1'b1;
    instr = {op, sh, rd, ra, rb, junk};
    rf_we = acc_we; rf_waddr = acc_addr; rf_wdata = acc_data;
    oa = m_r[ra];
    ob = m_r[rb];
    res = alu_fn(oa, ob, op, sh);
    exp_q.push_back(res);
    @(posedge clk);                        // accept edge N
    if (acc_we) m_r[acc_addr] = acc_data;
    @(negedge clk);                        // cycle N+1: ISSUE
    instr_valid = 1'b0;
    instr = 16'($urandom);
    rf_we = 1'b0;
    check("ready_issue", {7'b0, instr_ready}, 8'h00);
    check("done_issue", {7'b0, done}, 8'h00);
    check("alu_a", alu_a, oa);
    check("alu_b", alu_b, ob);
    check("alu_op", {5'b0, alu_op}, {5'b0, op});
    check("alu_shamt", {5'b0, alu_shamt}, {5'b0, sh});
    @(negedge clk);                        // cycle N+2: CAPTURE
    check("ready_capture", {7'b0, instr_ready}, 8'h00);
    check("done_capture", {7'b0, done}, 8'h01);
    rf_we = cap_we; rf_waddr = cap_addr; rf_wdata = cap_data;
    @(posedge clk);
    m_f = ref_flags(oa, ob, res, op, sh, m_f);
    if (cap_we) m_r[cap_addr] = cap_data;
    m_r[rd] = res;
    @(negedge clk);                        // cycle N+3: results visible
    rf_we = 1'b0;
    check("done_after", {7'b0, done}, 8'h00);
    check("ready_after", {7'b0, instr_ready}, 8'h01);
    check("flags", {4'b0, flags}, {4'b0, m_f});
    check("alu_a_hold", alu_a, oa);
    check("alu_b_hold", alu_b, ob);
    check_regs("regs");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       is_wr;
    logic [2:0] op;
    logic [2:0] sh;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] exp_val;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk_w(input logic [1:0] addr, input logic [7:0] data, input logic [3:0] f);
    vec_t v;
    v.is_wr = 1'b1; v.op = 3'd0; v.sh = 3'd0; v.rd = addr; v.ra = 2'd0; v.rb = 2'd0;
    v.exp_val = data; v.exp_flags = f;
    return v;
  endfunction

  function automatic vec_t mk_i(input logic [2:0] op, input logic [2:0] sh, input logic [1:0] rd,
                                input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] val, input logic [3:0] f);
    vec_t v;
    v.is_wr = 1'b0; v.op = op; v.sh = sh; v.rd = rd; v.ra = ra; v.rb = rb;
    v.exp_val = val; v.exp_flags = f;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int done_cnt;
    logic [7:0] ov;

    tbl[0]  = mk_w(2'd0, 8'h7F, RF);
    tbl[1]  = mk_w(2'd1, 8'h01, RF);
    tbl[2]  = mk_i(ADD, 3'd0, 2'd2, 2'd0, 2'd1, 8'h80, 4'b1001);
    tbl[3]  = mk_w(2'd1, 8'h05, 4'b1001);
    tbl[4]  = mk_i(SUB, 3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 4'b0110);
    tbl[5]  = mk_w(2'd3, 8'h81, 4'b0110);
    tbl[6]  = mk_i(LSL, 3'd1, 2'd3, 2'd3, 2'd0, 8'h02, 4'b0010);
    tbl[7]  = mk_i(AND_, 3'd0, 2'd3, 2'd3, 2'd3, 8'h02, 4'b0010);
    tbl[8]  = mk_i(LSR, 3'd3, 2'd0, 2'd2, 2'd0, 8'h10, 4'b0000);
    tbl[9]  = mk_i(NEG, 3'd0, 2'd1, 2'd0, 2'd0, 8'hF0, 4'b1000);
    tbl[10] = mk_i(ADD, 3'd0, 2'd2, 2'd1, 2'd1, 8'hE0, 4'b1010);
    tbl[11] = mk_i(SUB, 3'd0, 2'd0, 2'd3, 2'd2, 8'h22, 4'b0000);
    tbl[12] = mk_i(SUB, 3'd0, 2'd3, 2'd1, 2'd3, 8'hEE, 4'b1010);
    tbl[13] = mk_w(2'd0, 8'h80, 4'b1010);
    tbl[14] = mk_w(2'd1, 8'h01, 4'b1010);
    tbl[15] = mk_i(SUB, 3'd0, 2'd0, 2'd0, 2'd1, 8'h7F, 4'b0011);
    tbl[16] = mk_i(LSL, 3'd0, 2'd2, 2'd0, 2'd0, 8'h7F, 4'b0011);
    tbl[17] = mk_i(EOR, 3'd0, 2'd1, 2'd2, 2'd0, 8'h00, 4'b0111);
    tbl[18] = mk_i(ORR, 3'd0, 2'd3, 2'd1, 2'd0, 8'h7F, 4'b0011);
    tbl[19] = mk_i(LSR, 3'd7, 2'd1, 2'd2, 2'd0, 8'h00, 4'b0111);
    tbl[20] = mk_w(2'd2, 8'hFF, 4'b0111);
    tbl[21] = mk_i(ADD, 3'd0, 2'd0, 2'd2, 2'd2, 8'hFE, 4'b1010);

    // Reset state while held
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {7'b0, instr_ready}, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    check("rst_flags", {4'b0, flags}, {4'b0, RF});
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", {5'b0, alu_op}, 8'h00);
    check("rst_alu_shamt", {5'b0, alu_shamt}, 8'h00);
    check_regs("rst_regs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {7'b0, instr_ready}, 8'h01);

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].rd, tbl[i].exp_val);
      else run_instr(tbl[i].op, tbl[i].sh, tbl[i].rd, tbl[i].ra, tbl[i].rb,
                     1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
      rf_raddr = tbl[i].rd;
      #1;
      check("tbl_val", rf_rdata, tbl[i].exp_val);
      check("tbl_flags", {4'b0, flags}, {4'b0, tbl[i].exp_flags});
    end

    // Back-to-back: instr_valid held high, accepts every third cycle
    done_cnt = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {AND_, 3'd0, 2'd0, 2'd0, 2'd0, 4'h0};
    for (int k = 0; k < 9; k++) begin
      check("b2b_ready", {7'b0, instr_ready}, ((k % 3) == 0) ? 8'h01 : 8'h00);
      check("b2b_done", {7'b0, done}, ((k % 3) == 2) ? 8'h01 : 8'h00);
      if (done === 1'b1) done_cnt++;
      if ((k % 3) == 0) exp_q.push_back(m_r[0]);
      @(posedge clk);
      if ((k % 3) == 2) m_f = ref_flags(m_r[0], m_r[0], m_r[0], AND_, 3'd0, m_f);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_done_count", 8'(done_cnt), 8'd3);
    check("b2b_flags", {4'b0, flags}, {4'b0, m_f});

    // Collision on the CAPTURE edge: writeback wins on rd, other register written
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    run_instr(ADD, 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'hAA);
    rf_raddr = 2'd2; #1; check("coll_rd", rf_rdata, 8'h33);
    run_instr(ADD, 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'hAA);
    rf_raddr = 2'd3; #1; check("coll_other", rf_rdata, 8'hAA);

    // Write to ra/rb on the accept edge: old operand is latched
    run_instr(SUB, 3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 2'd1, 8'h99, 1'b0, 2'd0, 8'h00);
    run_instr(ADD, 3'd0, 2'd3, 2'd2, 2'd0, 1'b1, 2'd0, 8'h5A, 1'b0, 2'd0, 8'h00);

    // Randomized instructions with random concurrent writes
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) wr(2'($urandom), 8'($urandom));
      run_instr(3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom));
    end

    // Reset asserted during ISSUE aborts the instruction
    wr(2'd0, 8'h40);
    wr(2'd1, 8'h40);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {ADD, 3'd0, 2'd3, 2'd0, 2'd1, 4'h0};
    @(negedge clk);
    instr_valid = 1'b0;
    check("abort_ready_issue", {7'b0, instr_ready}, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("abort_done", {7'b0, done}, 8'h00);
    check("abort_ready", {7'b0, instr_ready}, 8'h00);
    check("abort_flags", {4'b0, flags}, {4'b0, RF});
    check("abort_alu_a", alu_a, 8'h00);
    check_regs("abort_regs");
    @(negedge clk);
    check("abort_done_late", {7'b0, done}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("abort_ready_release", {7'b0, instr_ready}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", {7'b0, done}, 8'h00);
    end
    check_regs("abort_regs_after");
    check("abort_flags_after", {4'b0, flags}, {4'b0, RF});

    // One more instruction after the abort to confirm normal operation resumes
    wr(2'd0, 8'h0F);
    run_instr(LSL, 3'd4, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    rf_raddr = 2'd1; #1; check("post_abort_lsl", rf_rdata, 8'hF0);

    ov = 8'(exp_q.size());
    check("queue_empty", ov, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
